// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller, 4-word lines, burst refill
// Optional statistics counters enabled by defining ICACHE_STATS_EN.
module icache_ctrl #(
  parameter int RAM_AW = 10,
  parameter int DATA_W = 32,
  parameter int CPU_AW = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [CPU_AW-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              inv,
  output logic              ram_wr_en,
  output logic [RAM_AW-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic [RAM_AW-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              mem_req,
  output logic [CPU_AW-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_hit_cnt,
  output logic [15:0]       stat_miss_cnt
);
  localparam int TAG_W     = CPU_AW - RAM_AW;
  localparam int IDX_W     = RAM_AW - 2;
  localparam int NUM_LINES = 1 << IDX_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_FILL_REQ  = 3'd2;
  localparam logic [2:0] S_FILL_DATA = 3'd3;
  localparam logic [2:0] S_REPLAY    = 3'd4;
  localparam logic [2:0] S_FLUSH     = 3'd5;

  logic [2:0]           state;
  logic [2:0]           state_nxt;
  logic [CPU_AW-1:0]    addr_q;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_mem [NUM_LINES];
  logic                 inv_pend;
  logic [1:0]           beat;

  logic [TAG_W-1:0]     addr_tag;
  logic [IDX_W-1:0]     addr_idx;
  logic                 hit;
  logic                 accept;
  logic                 beat_wr;
  logic                 last_beat;

  assign addr_tag  = addr_q[CPU_AW-1:RAM_AW];
  assign addr_idx  = addr_q[RAM_AW-1:2];
  assign hit       = valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);

  // A fresh inv blocks acceptance in the same cycle so the flush wins.
  assign cpu_ready = (state == S_IDLE) && !inv_pend && !inv;
  assign accept    = cpu_req && cpu_ready;
  assign beat_wr   = (state == S_FILL_DATA) && mem_rvalid;
  assign last_beat = beat_wr && (beat == 2'd3);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (inv_pend || inv) state_nxt = S_FLUSH;
        else if (cpu_req)    state_nxt = S_LOOKUP;
      end
      S_LOOKUP:    state_nxt = hit ? S_IDLE : S_FILL_REQ;
      S_FILL_REQ:  if (mem_gnt) state_nxt = S_FILL_DATA;
      S_FILL_DATA: if (last_beat) state_nxt = S_REPLAY;
      S_REPLAY:    state_nxt = S_LOOKUP;
      S_FLUSH:     state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      valid_q  <= '0;
      inv_pend <= 1'b0;
      beat     <= 2'd0;
    end else begin
      state <= state_nxt;
      if (accept) addr_q <= cpu_addr;
      if (state == S_FLUSH)  valid_q <= '0;
      else if (last_beat)    valid_q[addr_idx] <= 1'b1;
      if (inv)                    inv_pend <= 1'b1;
      else if (state == S_FLUSH)  inv_pend <= 1'b0;
      if (state == S_FILL_REQ) beat <= 2'd0;
      else if (beat_wr)        beat <= beat + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (last_beat) tag_mem[addr_idx] <= addr_tag;
  end

  // RAM read is registered inside the RAM, so LOOKUP sees the word addressed one cycle earlier.
  assign ram_rd_addr = (state == S_IDLE) ? cpu_addr[RAM_AW-1:0] : addr_q[RAM_AW-1:0];
  assign cpu_rvalid  = (state == S_LOOKUP) && hit;
  assign cpu_rdata   = ram_rd_data;

  assign ram_wr_en   = beat_wr;
  assign ram_wr_addr = {addr_idx, beat};
  assign ram_wr_data = mem_rdata;

  assign mem_req     = (state == S_FILL_REQ);
  assign mem_addr    = {addr_tag, addr_idx, 2'b00};

`ifdef ICACHE_STATS_EN
  logic        replay_lk;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  // The lookup following a refill is a guaranteed hit and is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      replay_lk <= 1'b0;
      hit_cnt   <= 16'd0;
      miss_cnt  <= 16'd0;
    end else begin
      replay_lk <= (state == S_REPLAY);
      if ((state == S_LOOKUP) && hit && !replay_lk && (hit_cnt != 16'hFFFF))
        hit_cnt <= hit_cnt + 16'd1;
      if ((state == S_LOOKUP) && !hit && (miss_cnt != 16'hFFFF))
        miss_cnt <= miss_cnt + 16'd1;
    end
  end

  assign stat_hit_cnt  = hit_cnt;
  assign stat_miss_cnt = miss_cnt;
`else
  assign stat_hit_cnt  = 16'd0;
  assign stat_miss_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - randomized self-checking bench for icache_ctrl
// Reference model: per-line valid/tag arrays, a data function for backing memory, stats tallies.
module tb_icache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req;
  logic [17:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        inv;
  logic        ram_wr_en;
  logic [9:0]  ram_wr_addr;
  logic [31:0] ram_wr_data;
  logic [9:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic        mem_req;
  logic [17:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [15:0] stat_hit_cnt;
  logic [15:0] stat_miss_cnt;

  logic        auto_mem;
  logic        resp_gnt, resp_rvalid, man_gnt, man_rvalid;
  logic [31:0] resp_rdata, man_rdata;
  int          r_gdly, r_gap;

  int          checks = 0;
  int          passes = 0;
  logic        mv [256];
  logic [7:0]  mt [256];
  int          exp_hits = 0;
  int          exp_misses = 0;

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .inv(inv),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stat_hit_cnt(stat_hit_cnt), .stat_miss_cnt(stat_miss_cnt)
  );

  assign mem_gnt    = auto_mem ? resp_gnt    : man_gnt;
  assign mem_rvalid = auto_mem ? resp_rvalid : man_rvalid;
  assign mem_rdata  = auto_mem ? resp_rdata  : man_rdata;

  // Data RAM: read address registered, data one cycle later.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram[ram_rd_addr];
  end

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    if (a[17:2] == 16'h0004) return 32'hA0 + 32'(a[1:0]);
    return 32'h3C00_0000 ^ (32'(a) * 32'd2654435761);
  endfunction

  // Backing-memory responder: grant after r_gdly cycles, r_gap idle cycles before each beat.
  initial begin
    logic [17:0] line;
    resp_gnt = 0; resp_rvalid = 0; resp_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_mem && mem_req) begin
        line = mem_addr;
        repeat (r_gdly) @(negedge clk);
        resp_gnt = 1;
        @(negedge clk);
        resp_gnt = 0;
        for (int b = 0; b < 4; b++) begin
          repeat (r_gap) @(negedge clk);
          resp_rvalid = 1;
          resp_rdata  = mem_word(line + 18'(b));
          @(negedge clk);
          resp_rvalid = 0;
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 256; i++) mv[i] = 1'b0;
  endtask

  task automatic fetch(input logic [17:0] a, input int gd, input int gp);
    logic        exp_miss, saw_req, got, ready_bad;
    logic [17:0] base;
    int          n, lat, nwr, exp_lat;
    exp_miss = !(mv[a[9:2]] && (mt[a[9:2]] == a[17:10]));
    base = {a[17:2], 2'b00};
    r_gdly = gd; r_gap = gp;
    @(negedge clk); cpu_req = 1; cpu_addr = a; #1;
    n = 0;
    while (!cpu_ready && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (cpu_ready !== 1'b1) $display("FAIL accept_timeout addr=%h ready=%b exp=1", a, cpu_ready);
    else passes++;
    checks++;
    if (ram_rd_addr !== a[9:0]) $display("FAIL idle_rd_addr got=%h exp=%h", ram_rd_addr, a[9:0]);
    else passes++;
    @(negedge clk); cpu_req = 0; #1;
    lat = 1; nwr = 0; saw_req = 0; got = 0; ready_bad = 0;
    while (lat < 300) begin
      if (mem_req) begin
        saw_req = 1;
        checks++;
        if (mem_addr !== base) $display("FAIL mem_addr got=%h exp=%h", mem_addr, base);
        else passes++;
      end
      if (ram_wr_en) begin
        checks++;
        if (nwr > 3 || ram_wr_addr !== {a[9:2], 2'(nwr)} || ram_wr_data !== mem_word(base + 18'(nwr)))
          $display("FAIL ram_write n=%0d got=%h/%h exp=%h/%h", nwr, ram_wr_addr, ram_wr_data,
                   {a[9:2], 2'(nwr)}, mem_word(base + 18'(nwr)));
        else passes++;
        nwr++;
      end
      if (cpu_ready) ready_bad = 1;
      if (cpu_rvalid) begin got = 1; break; end
      @(negedge clk); #1; lat++;
    end
    exp_lat = exp_miss ? 8 + gd + 4 * gp : 1;
    checks++;
    if (!got || cpu_rdata !== mem_word(a))
      $display("FAIL rdata addr=%h got=%h valid=%b exp=%h", a, cpu_rdata, got, mem_word(a));
    else passes++;
    checks++;
    if (saw_req !== exp_miss) $display("FAIL miss_detect addr=%h got=%b exp=%b", a, saw_req, exp_miss);
    else passes++;
    checks++;
    if (nwr !== (exp_miss ? 4 : 0)) $display("FAIL write_count got=%0d exp=%0d", nwr, exp_miss ? 4 : 0);
    else passes++;
    checks++;
    if (lat !== exp_lat) $display("FAIL latency addr=%h got=%0d exp=%0d", a, lat, exp_lat);
    else passes++;
    checks++;
    if (ready_bad !== 1'b0) $display("FAIL ready_busy got=1 exp=0");
    else passes++;
    if (exp_miss) begin
      mv[a[9:2]] = 1'b1; mt[a[9:2]] = a[17:10]; exp_misses++;
    end else exp_hits++;
  endtask

  task automatic do_inv_idle(input logic [17:0] a);
    @(negedge clk); cpu_req = 1; cpu_addr = a; inv = 1; #1;
    checks++;
    if (cpu_ready !== 1'b0) $display("FAIL inv_priority_ready got=%b exp=0", cpu_ready);
    else passes++;
    @(negedge clk); inv = 0; cpu_req = 0; #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (cpu_rvalid !== 1'b0 || mem_req !== 1'b0)
        $display("FAIL inv_not_accepted got=%b%b exp=00", cpu_rvalid, mem_req);
      else passes++;
      @(negedge clk); #1;
    end
    model_clear();
  endtask

  task automatic test_reset();
    rst_n = 0; cpu_req = 0; cpu_addr = '0; inv = 0; auto_mem = 1;
    man_gnt = 0; man_rvalid = 0; man_rdata = '0; r_gdly = 0; r_gap = 0;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_req, ram_wr_en, cpu_rvalid} !== 3'b000 || stat_hit_cnt !== 16'd0 || stat_miss_cnt !== 16'd0)
      $display("FAIL reset_outputs got=%b%b%b %h %h exp=000 0 0", mem_req, ram_wr_en, cpu_rvalid,
               stat_hit_cnt, stat_miss_cnt);
    else passes++;
    @(negedge clk); rst_n = 1; #1;
    checks++;
    if (cpu_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", cpu_ready);
    else passes++;
  endtask

  task automatic test_stats();
`ifdef ICACHE_STATS_EN
    checks++;
    if (stat_hit_cnt !== 16'(exp_hits) || stat_miss_cnt !== 16'(exp_misses))
      $display("FAIL stats got=%0d/%0d exp=%0d/%0d", stat_hit_cnt, stat_miss_cnt, exp_hits, exp_misses);
    else passes++;
`else
    checks++;
    if (stat_hit_cnt !== 16'd0 || stat_miss_cnt !== 16'd0)
      $display("FAIL stats_tied got=%0d/%0d exp=0/0", stat_hit_cnt, stat_miss_cnt);
    else passes++;
`endif
  endtask

  task automatic test_basic();
    fetch(18'h00010, 0, 0);
    fetch(18'h00012, 0, 0);
    test_stats();
  endtask

  task automatic test_conflict();
    fetch(18'h00410, 1, 0);
    fetch(18'h00010, 0, 1);
  endtask

  task automatic test_gaps();
    fetch(18'h002A4, 5, 3);
    fetch(18'h002A7, 0, 0);
  endtask

  task automatic test_inv_idle();
    fetch(18'h00011, 0, 0);
    do_inv_idle(18'h00011);
    fetch(18'h00011, 0, 0);
  endtask

  task automatic test_inv_fill();
    fork
      fetch(18'h01234, 2, 2);
      begin
        repeat (6) @(negedge clk);
        inv = 1;
        @(negedge clk);
        inv = 0;
      end
    join
    model_clear();
    fetch(18'h01234, 0, 0);
  endtask

  task automatic test_reset_midfill();
    logic [17:0] a;
    int n;
    a = {8'h2C, 8'h35, 2'b01};
    auto_mem = 0;
    @(negedge clk); cpu_req = 1; cpu_addr = a; #1;
    n = 0;
    while (!cpu_ready && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk); cpu_req = 0; #1;
    n = 0;
    while (!mem_req && n < 50) begin @(negedge clk); #1; n++; end
    checks++;
    if (mem_req !== 1'b1) $display("FAIL rmf_mem_req got=%b exp=1", mem_req);
    else passes++;
    man_gnt = 1;
    @(negedge clk); man_gnt = 0; man_rvalid = 1; man_rdata = 32'hDEAD_0000; #1;
    checks++;
    if (ram_wr_en !== 1'b1 || ram_wr_addr !== {a[9:2], 2'b00})
      $display("FAIL rmf_beat0 got=%b/%h exp=1/%h", ram_wr_en, ram_wr_addr, {a[9:2], 2'b00});
    else passes++;
    @(negedge clk); man_rdata = 32'hDEAD_0001;
    @(negedge clk); man_rvalid = 0; rst_n = 0; #1;
    checks++;
    if ({mem_req, ram_wr_en, cpu_rvalid} !== 3'b000)
      $display("FAIL rmf_in_reset got=%b%b%b exp=000", mem_req, ram_wr_en, cpu_rvalid);
    else passes++;
    @(negedge clk); rst_n = 1; #1;
    checks++;
    if (cpu_ready !== 1'b1) $display("FAIL rmf_ready got=%b exp=1", cpu_ready);
    else passes++;
    man_rvalid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ram_wr_en !== 1'b0) $display("FAIL rmf_stray_beat got=%b exp=0", ram_wr_en);
      else passes++;
      @(negedge clk);
    end
    man_rvalid = 0; auto_mem = 1;
    model_clear(); exp_hits = 0; exp_misses = 0;
    test_stats();
    fetch(a, 1, 1);
  endtask

  task automatic test_random();
    logic [17:0] a;
    for (int i = 0; i < 40; i++) begin
      a = {8'($urandom_range(0, 2)), 8'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) do_inv_idle(a);
      fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
    test_stats();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_conflict();
    test_gaps();
    test_inv_idle();
    test_inv_fill();
    test_reset_midfill();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
